// File: rtl/my_ram_4_way.sv
// Four-word register bank fed by a 4-way load demux, with a registered read port.
// Define MY_RAM_4_WAY_FWD_EN for write-first forwarding on same-edge load/read; default is read-first.
module my_ram_4_way #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [1:0]       address,
  input  logic             rd_en,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [3:0]       written,
  output logic [7:0]       wr_count
);

  logic [WIDTH-1:0] words [4];
  logic [3:0]       load_sel;
  logic [WIDTH-1:0] rd_data;

  always_comb begin
    load_sel = 4'b0000;
    if (load) load_sel[address] = 1'b1;
  end

`ifdef MY_RAM_4_WAY_FWD_EN
  assign rd_data = load ? in : words[address];
`else
  assign rd_data = words[address];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) words[i] <= '0;
      written <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load_sel[i]) begin
          words[i]   <= in;
          written[i] <= 1'b1;
        end
      end
    end
  end

  // Write counter sticks at 255 rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count <= 8'd0;
    end else if (load && (wr_count != 8'hFF)) begin
      wr_count <= wr_count + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= rd_en;
      if (rd_en) out <= rd_data;
    end
  end

endmodule

// File: tb/tb_my_ram_4_way.sv
// Randomised self-checking bench for my_ram_4_way against a behavioural model.
// Honours MY_RAM_4_WAY_FWD_EN the same way as the design.
module tb_my_ram_4_way;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        load;
  logic [1:0]  address;
  logic        rd_en;
  logic [15:0] out;
  logic        out_valid;
  logic [3:0]  written;
  logic [7:0]  wr_count;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [15:0] m_words [4];
  logic [15:0] m_out;
  logic        m_valid;
  logic [3:0]  m_written;
  int          m_count;
`ifdef MY_RAM_4_WAY_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  my_ram_4_way #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in(in_data), .load(load), .address(address),
    .rd_en(rd_en), .out(out), .out_valid(out_valid), .written(written),
    .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Model: a read returns the stored word (or the incoming data in forwarding mode),
  // and a write stores data, marks the word and bumps a saturating count.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_words[i] = 16'h0;
      m_out     = 16'h0;
      m_valid   = 1'b0;
      m_written = 4'b0;
      m_count   = 0;
    end else begin
      m_valid = rd_en;
      if (rd_en) m_out = (FWD && load) ? in_data : m_words[address];
      if (load) begin
        m_words[address]   = in_data;
        m_written[address] = 1'b1;
        m_count            = (m_count + 1 > 255) ? 255 : m_count + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model_out", {16'h0, out}, {16'h0, m_out});
    checkOutput("model_out_valid", {31'h0, out_valid}, {31'h0, m_valid});
    checkOutput("model_written", {28'h0, written}, {28'h0, m_written});
    checkOutput("model_wr_count", {24'h0, wr_count}, m_count);
  end

  task automatic applyStimulus(input logic ld, input logic rd, input logic [1:0] addr,
                               input logic [15:0] data);
    load    = ld;
    rd_en   = rd;
    address = addr;
    in_data = data;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] pattern [4];
  logic [15:0] last_data;

  initial begin
    pattern[0] = 16'h1111; pattern[1] = 16'h2222;
    pattern[2] = 16'h3333; pattern[3] = 16'h4444;
    rst = 1'b1; load = 0; rd_en = 0; address = 0; in_data = 0;
    #1;
    checkOutput("reset_out", {16'h0, out}, 32'h0);
    checkOutput("reset_valid", {31'h0, out_valid}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset and empty read
    applyStimulus(0, 1, 2'd2, 16'h0);
    checkOutput("empty_read_out", {16'h0, out}, 32'h0);
    checkOutput("empty_read_valid", {31'h0, out_valid}, 32'h1);
    checkOutput("empty_written", {28'h0, written}, 32'h0);
    checkOutput("empty_count", {24'h0, wr_count}, 32'h0);

    // Demux routing, then back-to-back reads
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 2'(i), pattern[i]);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 2'(i), 16'h0);
      checkOutput("route_out", {16'h0, out}, {16'h0, pattern[i]});
      checkOutput("route_valid", {31'h0, out_valid}, 32'h1);
    end
    checkOutput("route_written", {28'h0, written}, 32'hF);
    checkOutput("route_count", {24'h0, wr_count}, 32'd4);

    // Idle hold after reading word0
    applyStimulus(0, 1, 2'd0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 2'd0, 16'h0);
      checkOutput("idle_out", {16'h0, out}, 32'h1111);
      checkOutput("idle_valid", {31'h0, out_valid}, 32'h0);
    end

    // Same-edge read and write of word1
    applyStimulus(1, 1, 2'd1, 16'hBEEF);
    checkOutput("same_edge_out", {16'h0, out}, FWD ? 32'hBEEF : 32'h2222);
    applyStimulus(0, 1, 2'd1, 16'h0);
    checkOutput("same_edge_reread", {16'h0, out}, 32'hBEEF);
    checkOutput("same_edge_count", {24'h0, wr_count}, 32'd5);

    // Random traffic
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 16'($urandom));

    // Saturation
    last_data = 16'h0;
    for (int i = 0; i < 300; i++) begin
      last_data = 16'($urandom);
      applyStimulus(1, 0, 2'd3, last_data);
    end
    applyStimulus(0, 1, 2'd3, 16'h0);
    checkOutput("sat_count", {24'h0, wr_count}, 32'd255);
    checkOutput("sat_word3", {16'h0, out}, {16'h0, last_data});
    applyStimulus(1, 0, 2'd0, 16'h1234);
    checkOutput("sat_hold", {24'h0, wr_count}, 32'd255);

    // Async reset between edges, just after a read
    applyStimulus(0, 1, 2'd3, 16'h0);
    rd_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_out", {16'h0, out}, 32'h0);
    checkOutput("async_rst_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("async_rst_count", {24'h0, wr_count}, 32'h0);
    // Load and read requested while reset is held are dropped
    applyStimulus(1, 1, 2'd2, 16'hA5A5);
    rst = 1'b0;
    applyStimulus(0, 0, 2'd0, 16'h0);
    checkOutput("post_rst_valid", {31'h0, out_valid}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 2'(i), 16'h0);
      checkOutput("post_rst_read", {16'h0, out}, 32'h0);
    end
    checkOutput("post_rst_written", {28'h0, written}, 32'h0);
    applyStimulus(0, 0, 2'd0, 16'h0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/my_ram_4_way.md
# my_ram_4_way

Four-word register bank that sits directly downstream of the 4-way demultiplexer. The demux routes `load` to exactly one of four word registers selected by `address`. A registered read port returns the addressed word one cycle later with a valid strobe. It is the next building block toward the RAM8/RAM64 hierarchy.

## Interface
Parameters:
- `WIDTH`, 16: word width in bits.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `in`  input  WIDTH  write data.
- `load`  input  1  write strobe; demuxed by `address` to one word.
- `address`  input  2  word select for both write and read.
- `rd_en`  input  1  read request; samples `address` on this edge.
- `out`  output  WIDTH  registered read data.
- `out_valid`  output  1  high for exactly one cycle when `out` carries the result of a read.
- `written`  output  4  bit k is set once word k has been loaded since reset.
- `wr_count`  output  8  number of accepted writes since reset; saturates at 255.

## Operation
- Write path:
  - `load` is decoded through the demux: `address`=00 selects word0, 01 word1, 10 word2, 11 word3.
  - At most one word loads per edge.
  - On a rising edge with `load`=1: `word[address]` <= `in` and `written[address]` <= 1.
  - `wr_count` increments by 1 unless it is already 255, where it holds.
- Read path:
  - On a rising edge with `rd_en`=1: `out` <= `word[address]` and `out_valid` <= 1.
  - With `rd_en`=0: `out` holds its last value and `out_valid` <= 0.
- Reading a never-written word returns 0 with `out_valid`=1; `written` lets the consumer distinguish this case.
- Simultaneous `load` and `rd_en` on the same edge share one `address`, so they target the same word. The read result follows Configuration.
- `load`=1 with `in` equal to the stored value still counts as a write: `wr_count` increments and `written` sets.
- No handshake back-pressure: every `load` and `rd_en` is accepted on the edge it is sampled.

## Timing
- Reset values (asynchronous, immediate on `rst` rising):
  - all words = 0
  - `out` = 0
  - `out_valid` = 0
  - `written` = 4'b0000
  - `wr_count` = 0
- Reset mid-operation: a read requested on the edge where `rst` is high is dropped, with no `out_valid` after release. Writes on that edge are discarded.
- After `rst` deasserts, the first active edge operates normally.
- Write latency: a new value is visible to a read sampled on the next edge (1 cycle).
- Read latency: `out` and `out_valid` are valid 1 cycle after the `rd_en` edge.
- Back-to-back reads on consecutive edges give consecutive `out_valid` pulses with no bubble.
- `wr_count` wrap-around is forbidden: 255 plus a write gives 255.

## Configuration
- Macro: `MY_RAM_4_WAY_FWD_EN`.
- Defined: a same-edge `load` and `rd_en` return the new data, i.e. `out` <= `in` (write-first forwarding).
- Undefined: a same-edge `load` and `rd_en` return the old stored word (read-first).
- In both modes the word is updated and `wr_count` increments identically.

## Test plan
- Reset and empty read:
  - Stimulus: assert `rst`, release, `rd_en`=1 with `address`=2.
  - Required: next cycle `out`=0, `out_valid`=1, `written`=0000, `wr_count`=0.
- Demux routing:
  - Stimulus: load 0x1111, 0x2222, 0x3333, 0x4444 to addresses 0–3, then read 0–3 on consecutive edges.
  - Required: `out` is 0x1111, 0x2222, 0x3333, 0x4444 on four consecutive cycles with `out_valid` continuously 1; `written`=1111; `wr_count`=4.
- Same-edge read/write:
  - Stimulus: word1 holds 0x2222; on one edge drive `load`=1, `rd_en`=1, `address`=1, `in`=0xBEEF.
  - Required: `out`=0x2222 without the macro, 0xBEEF with it; a subsequent read of word1 returns 0xBEEF in both modes.
- Saturation:
  - Stimulus: 300 consecutive writes to `address`=3.
  - Required: `wr_count`=255 and holds; word3 equals the last `in`.
- Asynchronous reset mid-read:
  - Stimulus: `rd_en`=1 on an edge, then assert `rst` between edges.
  - Required: `out`=0 and `out_valid`=0 immediately, with no clock needed; all words read back 0 after release.
- Idle hold:
  - Stimulus: read word0=0x1111, then hold `rd_en`=0 for 3 cycles.
  - Required: `out` stays 0x1111, `out_valid`=0 on all three cycles.
